// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit arbiter
package uart_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_LOAD,
        ARB_SEND
    } arb_state_t;

    localparam int UART_DATA_BITS   = 8;
    // 16 sTicks each for start bit, every data bit and the stop bit
    localparam int UART_FRAME_TICKS = 160;
    // frame tick counter width; must hold UART_FRAME_TICKS-1
    localparam int UART_TICK_W      = 8;

endpackage

// File: rtl/uart_arb_pick.sv
// rtl/uart_arb_pick.sv - combinational winner select; rotating search under UART_TX_ARB_RR_EN
module uart_arb_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      w,
    output logic               valid
);

`ifdef UART_TX_ARB_RR_EN
    int idx;

    // Search upward from rr_ptr with wrap; walking downward lets the closest hit win.
    always_comb begin
        w     = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[idx]) begin
                w     = IW'(idx);
                valid = 1'b1;
            end
        end
    end
`else
    logic unused_rr_ptr;
    assign unused_rr_ptr = ^rr_ptr;

    // Fixed priority: walking downward leaves the lowest requesting index as winner.
    always_comb begin
        w     = '0;
        valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                w     = IW'(k);
                valid = 1'b1;
            end
        end
    end
`endif

    assign grant = valid ? (NUM_REQ'(1) << w) : '0;

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one 8N1 UART transmitter among NUM_REQ sources; round-robin when UART_TX_ARB_RR_EN is defined
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int FRAME_TICKS = UART_FRAME_TICKS,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sTick,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_BITS-1:0]  reqData,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          txStart,
    output logic [DATA_BITS-1:0]          din,
    input  logic                          txDoneTick,
    output logic                          busy,
    output logic [IW-1:0]                 grantId
);

    localparam logic [UART_TICK_W-1:0] LAST_TICK = UART_TICK_W'(FRAME_TICKS - 1);

    arb_state_t             state;
    arb_state_t             state_next;
    logic [DATA_BITS-1:0]   hold_reg;
    logic [UART_TICK_W-1:0] tick_cnt;
    logic [IW-1:0]          grant_id;
    logic [IW-1:0]          rr_ptr;

    logic [NUM_REQ-1:0]     pick_grant;
    logic [IW-1:0]          pick_w;
    logic                   pick_valid;

    logic                   take;
    logic                   frame_end;

    uart_arb_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .grant  (pick_grant),
        .w      (pick_w),
        .valid  (pick_valid)
    );

    // A byte is captured only from IDLE; reset suppresses ack so no source drops a byte we discard.
    assign take      = (state == ARB_IDLE) && pick_valid && !reset;
    assign frame_end = (state == ARB_SEND) && sTick && (tick_cnt == LAST_TICK);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and transmitter-facing outputs; din stays on hold_reg for the whole frame.
    always_comb begin
        state_next = state;
        ack        = '0;
        txStart    = 1'b0;
        din        = '0;
        case (state)
            ARB_IDLE: begin
                if (take) begin
                    ack        = pick_grant;
                    state_next = ARB_LOAD;
                end
            end
            ARB_LOAD: begin
                txStart = 1'b1;
                din     = hold_reg;
                if (txDoneTick) begin
                    state_next = ARB_SEND;
                end
            end
            ARB_SEND: begin
                din = hold_reg;
                if (frame_end) begin
                    state_next = ARB_IDLE;
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    assign busy    = (state != ARB_IDLE);
    assign grantId = grant_id;

    // Hold register, granted index and frame tick counter; sTicks only count once in SEND.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_reg <= '0;
            grant_id <= '0;
            tick_cnt <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (take) begin
                        hold_reg <= reqData[int'(pick_w)*DATA_BITS +: DATA_BITS];
                        grant_id <= pick_w;
                    end
                end
                ARB_LOAD: begin
                    tick_cnt <= '0;
                end
                ARB_SEND: begin
                    if (sTick) begin
                        if (tick_cnt == LAST_TICK) begin
                            tick_cnt <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    tick_cnt <= '0;
                end
            endcase
        end
    end

`ifdef UART_TX_ARB_RR_EN
    // Rotate the search start to just past the last winner.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (take) begin
            if (int'(pick_w) == NUM_REQ - 1) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= pick_w + 1'b1;
            end
        end
    end
`else
    assign rr_ptr = '0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter (vector table, corner sequences, random vs model)
module tb_uart_tx_arbiter;

    localparam int NR = 2;
    localparam int DB = 8;
    localparam int FT = 160;
`ifdef UART_TX_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             sTick;
    logic [NR-1:0]    req;
    logic [NR*DB-1:0] reqData;
    logic [NR-1:0]    ack;
    logic             txStart;
    logic [DB-1:0]    din;
    logic             txDoneTick;
    logic             busy;
    logic [0:0]       grantId;
    logic             stall;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;
    int period = 1;
    bit rand_stick = 1'b0;

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_BITS(DB), .FRAME_TICKS(FT)) dut (
        .clk        (clk),
        .reset      (reset),
        .sTick      (sTick),
        .req        (req),
        .reqData    (reqData),
        .ack        (ack),
        .txStart    (txStart),
        .din        (din),
        .txDoneTick (txDoneTick),
        .busy       (busy),
        .grantId    (grantId)
    );

    // idle transmitter model: takes txStart at once unless the bench stalls it
    assign txDoneTick = txStart & ~stall;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        sTick = rand_stick ? ($urandom_range(0, 1) == 0) : ((cyc % period) == 0);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1; req = '0; reqData = '0; stall = 1'b0;
        step(); step(); settle();
        chk({tag, " rst ack"}, ack, 0);
        chk({tag, " rst txStart"}, txStart, 0);
        chk({tag, " rst din"}, din, 0);
        chk({tag, " rst busy"}, busy, 0);
        chk({tag, " rst grantId"}, grantId, 0);
        reset = 1'b0;
    endtask

    // Follows one frame from its LOAD (or SEND) cycle until busy drops.
    task automatic run_frame(input logic [7:0] exp_din, input string tag,
                             input int late_tick, input logic [7:0] late_data, output int width);
        int ticks = 0;
        int bad_din = 0;
        int bad_ack = 0;
        int n = 0;
        int k;
        logic [9:0] line = '0;
        width = 0;
        while (busy === 1'b1 && n < 20000) begin
            n++; width++;
            if (din !== exp_din) bad_din++;
            if (ack !== '0) bad_ack++;
            if (!txStart && sTick) begin
                if (ticks % 16 == 8) begin
                    k = ticks / 16;
                    line[k] = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : din[k-1];
                end
                ticks++;
            end
            step();
            if (late_tick >= 0 && ticks == late_tick && req[1] == 1'b0) begin
                req[1] = 1'b1;
                reqData[15:8] = late_data;
            end
            settle();
        end
        chk({tag, " frame ends"}, busy, 0);
        chk({tag, " sTicks"}, ticks, FT);
        chk({tag, " din stable"}, bad_din, 0);
        chk({tag, " no ack busy"}, bad_ack, 0);
        chk({tag, " tx line"}, line, {1'b1, exp_din, 1'b0});
    endtask

    typedef struct {
        logic [1:0] rq;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] ack_fx;
        logic [1:0] ack_rr;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [1:0] ea;
        logic [7:0] ed;
        logic [7:0] seq [4];
        sTick = 1'b0; reset = 1'b1; req = '0; reqData = '0; stall = 1'b0;

        tbl[0] = '{2'b01, 8'hA5, 8'h00, 2'b01, 2'b01};
        tbl[1] = '{2'b10, 8'h00, 8'h3C, 2'b10, 2'b10};
        tbl[2] = '{2'b11, 8'h11, 8'h22, 2'b01, 2'b01};
        tbl[3] = '{2'b11, 8'h5A, 8'hC3, 2'b01, 2'b10};
        tbl[4] = '{2'b11, 8'h00, 8'hFF, 2'b01, 2'b01};
        tbl[5] = '{2'b10, 8'h00, 8'h7E, 2'b10, 2'b10};

        // vector table, sTick every cycle
        period = 1;
        do_reset("tbl");
        for (int i = 0; i < 6; i++) begin
            req = tbl[i].rq; reqData = {tbl[i].d1, tbl[i].d0};
            settle();
            ea = RR ? tbl[i].ack_rr : tbl[i].ack_fx;
            ed = ea[1] ? tbl[i].d1 : tbl[i].d0;
            chk($sformatf("tbl%0d ack", i), ack, ea);
            step(); req = '0; settle();
            chk($sformatf("tbl%0d txStart", i), txStart, 1);
            chk($sformatf("tbl%0d grantId", i), grantId, ea[1]);
            run_frame(ed, $sformatf("tbl%0d", i), -1, 8'h00, w);
            chk($sformatf("tbl%0d busy width", i), w, FT + 1);
        end

        // contention with both requests held high
        do_reset("cont");
        seq = RR ? '{8'h11, 8'h22, 8'h11, 8'h22} : '{8'h11, 8'h11, 8'h11, 8'h11};
        req = 2'b11; reqData = {8'h22, 8'h11};
        for (int f = 0; f < 4; f++) begin
            settle();
            chk($sformatf("cont%0d ack", f), ack, (seq[f] == 8'h22) ? 2'b10 : 2'b01);
            step(); settle();
            run_frame(seq[f], $sformatf("cont%0d", f), -1, 8'h00, w);
        end
        req = '0;

        // request arriving at sTick 40 of a running frame
        do_reset("late");
        req = 2'b01; reqData = {8'h00, 8'h5A}; settle();
        chk("late first ack", ack, 2'b01);
        step(); req = '0; settle();
        run_frame(8'h5A, "late f0", 40, 8'hC6, w);
        chk("late ack after busy", ack, 2'b10);
        step(); req = '0; settle();
        chk("late txStart", txStart, 1);
        run_frame(8'hC6, "late f1", -1, 8'h00, w);

        // stalled txDoneTick in LOAD
        do_reset("stall");
        stall = 1'b1;
        req = 2'b01; reqData = {8'h00, 8'h96}; settle();
        chk("stall ack", ack, 2'b01);
        step(); req = 2'b10; reqData = {8'h44, 8'h96}; settle();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d txStart", c), txStart, 1);
            chk($sformatf("stall%0d ack", c), ack, 0);
            step(); settle();
        end
        stall = 1'b0; settle();
        chk("stall release txStart", txStart, 1);
        step(); settle();
        chk("stall send txStart", txStart, 0);
        chk("stall send busy", busy, 1);
        run_frame(8'h96, "stall", -1, 8'h00, w);
        req = '0;

        // reset at sTick 80
        do_reset("midrst");
        req = 2'b10; reqData = {8'h3C, 8'h00}; settle();
        chk("midrst ack", ack, 2'b10);
        step(); req = '0; settle();
        begin
            int t = 0;
            int n = 0;
            while (t < 80 && n < 2000) begin
                if (!txStart && sTick) t++;
                step(); settle(); n++;
            end
        end
        chk("midrst busy pre", busy, 1);
        chk("midrst grantId pre", grantId, 1);
        reset = 1'b1; step(); reset = 1'b0; settle();
        chk("midrst busy", busy, 0);
        chk("midrst txStart", txStart, 0);
        chk("midrst din", din, 0);
        chk("midrst grantId", grantId, 0);
        chk("midrst ack", ack, 0);
        req = 2'b10; reqData = {8'hE7, 8'h00}; settle();
        chk("midrst new ack", ack, 2'b10);
        step(); req = '0; settle();
        chk("midrst new txStart", txStart, 1);
        run_frame(8'hE7, "midrst", -1, 8'h00, w);

        // sTick every 27 cycles
        do_reset("p27");
        period = 27;
        req = 2'b01; reqData = {8'h00, 8'h81}; settle();
        step(); req = '0; settle();
        run_frame(8'h81, "p27", -1, 8'h00, w);
        chk("p27 width range", (w >= 159*27 + 2) && (w <= 160*27 + 1), 1);
        period = 1;

        // random stimulus against a frame-level model
        do_reset("rnd");
        rand_stick = 1'b1;
        begin
            bit          m_free = 1'b1;
            bit          m_load = 1'b0;
            int          m_cnt = 0;
            int          m_rr = 0;
            logic [7:0]  m_byte = 8'h00;
            bit [NR-1:0] pend = '0;
            logic [7:0]  pdata [NR];
            int          win;
            for (int i = 0; i < NR; i++) pdata[i] = 8'h00;
            for (int c = 0; c < 6000; c++) begin
                settle();
                win = -1;
                if (m_free && pend != '0) begin
                    for (int k = NR - 1; k >= 0; k--) begin
                        int i = RR ? ((m_rr + k) % NR) : k;
                        if (pend[i]) win = i;
                    end
                end
                chk("rnd ack", ack, (win >= 0) ? (1 << win) : 0);
                chk("rnd busy", busy, !m_free);
                chk("rnd txStart", txStart, m_load);
                if (!m_free) chk("rnd din", din, m_byte);
                if (win >= 0) begin
                    m_free = 1'b0; m_load = 1'b1; m_cnt = 0;
                    m_byte = pdata[win]; m_rr = (win + 1) % NR; pend[win] = 1'b0;
                end else if (!m_free) begin
                    if (m_load) begin
                        if (!stall) m_load = 1'b0;
                    end else if (sTick) begin
                        m_cnt++;
                        if (m_cnt == FT) m_free = 1'b1;
                    end
                end
                step();
                stall = ($urandom_range(0, 3) == 0);
                for (int i = 0; i < NR; i++) begin
                    if (i == win) begin
                        req[i] = 1'b0;
                    end else if (!pend[i] && $urandom_range(0, 99) < 4) begin
                        pend[i] = 1'b1;
                        pdata[i] = 8'($urandom);
                        req[i] = 1'b1;
                        reqData[i*8 +: 8] = pdata[i];
                    end
                end
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
